// File: rtl/cam_sched.sv
// Single-issue scheduler between two requesters and a CAM with fixed read/search latency.
// Round-robin arbitration, one operation in flight, registered strobes and responses.
module cam_sched #(
    parameter int LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic [1:0]  op0_i,
    input  logic [1:0]  op1_i,
    input  logic [4:0]  idx0_i,
    input  logic [4:0]  idx1_i,
    input  logic [31:0] data0_i,
    input  logic [31:0] data1_i,
    output logic        gnt0_o,
    output logic        gnt1_o,
    output logic        cam_re_o,
    output logic        cam_we_o,
    output logic        cam_se_o,
    output logic [4:0]  cam_idx_o,
    output logic [31:0] cam_data_o,
    input  logic [31:0] cam_rdata_i,
    input  logic [31:0] cam_match_i,
    output logic        rsp_valid_o,
    output logic        rsp_id_o,
    output logic        rsp_hit_o,
    output logic [4:0]  rsp_idx_o,
    output logic [31:0] rsp_data_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SEARCH = 2'b10;

    state_t      state;
    logic        last;
    logic [1:0]  cnt;
    logic [1:0]  op_q;
    logic [4:0]  idx_q;
    logic [31:0] data_q;
    logic        id_q;

    logic        win;
    logic [1:0]  sel_op;
    logic [4:0]  sel_idx;
    logic [31:0] sel_data;
    logic [4:0]  match_idx;

    // On contention the requester not granted last wins; a lone requester always wins.
    always_comb begin
        win      = (req0_i && req1_i) ? ~last : req1_i;
        sel_op   = win ? op1_i : op0_i;
        sel_idx  = win ? idx1_i : idx0_i;
        sel_data = win ? data1_i : data0_i;
    end

    // Highest-numbered matching entry; 31 doubles as the no-match index.
    always_comb begin
        match_idx = 5'd31;
        for (int i = 0; i < 32; i++) begin
            if (cam_match_i[i]) match_idx = 5'(i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            last        <= 1'b1;
            cnt         <= 2'd0;
            op_q        <= 2'd0;
            idx_q       <= 5'd0;
            data_q      <= 32'd0;
            id_q        <= 1'b0;
            gnt0_o      <= 1'b0;
            gnt1_o      <= 1'b0;
            cam_re_o    <= 1'b0;
            cam_we_o    <= 1'b0;
            cam_se_o    <= 1'b0;
            cam_idx_o   <= 5'd0;
            cam_data_o  <= 32'd0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= 1'b0;
            rsp_hit_o   <= 1'b0;
            rsp_idx_o   <= 5'd0;
            rsp_data_o  <= 32'd0;
        end else begin
            gnt0_o      <= 1'b0;
            gnt1_o      <= 1'b0;
            cam_re_o    <= 1'b0;
            cam_we_o    <= 1'b0;
            cam_se_o    <= 1'b0;
            cam_idx_o   <= 5'd0;
            cam_data_o  <= 32'd0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= 1'b0;
            rsp_hit_o   <= 1'b0;
            rsp_idx_o   <= 5'd0;
            rsp_data_o  <= 32'd0;
            case (state)
                IDLE: begin
                    if (req0_i || req1_i) begin
                        state      <= ISSUE;
                        last       <= win;
                        id_q       <= win;
                        op_q       <= sel_op;
                        idx_q      <= sel_idx;
                        data_q     <= sel_data;
                        gnt0_o     <= ~win;
                        gnt1_o     <= win;
                        cam_re_o   <= (sel_op == OP_READ);
                        cam_we_o   <= (sel_op == OP_WRITE);
                        cam_se_o   <= (sel_op == OP_SEARCH);
                        cam_idx_o  <= sel_idx;
                        cam_data_o <= sel_data;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    cnt   <= 2'(LAT);
                end
                WAIT: begin
                    // Final count is the cycle the CAM result is valid.
                    if (cnt == 2'd1) begin
                        state       <= RESP;
                        cnt         <= 2'd0;
                        rsp_valid_o <= 1'b1;
                        rsp_id_o    <= id_q;
                        case (op_q)
                            OP_READ: begin
                                rsp_hit_o  <= 1'b1;
                                rsp_idx_o  <= idx_q;
                                rsp_data_o <= cam_rdata_i;
                            end
                            OP_WRITE: begin
                                rsp_hit_o  <= 1'b1;
                                rsp_idx_o  <= idx_q;
                                rsp_data_o <= data_q;
                            end
                            OP_SEARCH: begin
                                rsp_hit_o  <= |cam_match_i;
                                rsp_idx_o  <= match_idx;
                                rsp_data_o <= data_q;
                            end
                            default: begin
                                rsp_hit_o  <= 1'b0;
                                rsp_idx_o  <= 5'd0;
                                rsp_data_o <= 32'd0;
                            end
                        endcase
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
